// File: rtl/wr_ingress_ctrl.sv
// Write-domain ingress for the async FIFO: two-entry skid buffer feeding the FIFO write port,
// plus the read-pointer synchroniser and a registered fill level / almost-full estimate.
module wr_ingress_ctrl #(
  parameter int ptr_width    = 8,
  parameter int data_width   = 8,
  parameter int afull_thresh = 2**ptr_width - 4
) (
  input  logic                  wclk,
  input  logic                  w_rst_n,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in_data,
  output logic                  in_ready,
  input  logic                  full,
  input  logic [ptr_width:0]    waddr,
  input  logic [ptr_width:0]    rptr_gray,
  output logic                  w_en,
  output logic [data_width-1:0] wdata,
  output logic [ptr_width:0]    rptr_sync,
  output logic [ptr_width:0]    wr_level,
  output logic                  almost_full
);

  localparam logic [ptr_width:0] AFULL = (ptr_width+1)'(afull_thresh);

  function automatic logic [ptr_width:0] gray2bin(input logic [ptr_width:0] g);
    logic [ptr_width:0] b;
    for (int i = 0; i <= ptr_width; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  logic                  r_main_valid;
  logic [data_width-1:0] r_main_data;
  logic                  r_skid_valid;
  logic [data_width-1:0] r_skid_data;
  logic [ptr_width:0]    r_s1;
  logic [ptr_width:0]    r_rptr_sync;
  logic [ptr_width:0]    r_wr_level;
  logic                  r_almost_full;

  logic                  w_accept;
  logic                  w_drain;
  logic [ptr_width:0]    w_rbin;
  logic [ptr_width:0]    w_level;

  // Reset gates the handshake combinationally so nothing moves while w_rst_n is low.
  assign w_drain  = r_main_valid & ~full & w_rst_n;
  assign in_ready = ~r_skid_valid & w_rst_n;
  assign w_accept = in_valid & in_ready;
  assign w_en     = w_drain;
  assign wdata    = r_main_data;

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
    end else if (w_drain) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_main_data  <= in_data;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_main_valid) begin
        r_main_valid <= 1'b1;
        r_main_data  <= in_data;
      end else begin
        r_skid_valid <= 1'b1;
        r_skid_data  <= in_data;
      end
    end
  end

  // Modulo subtraction handles pointer wrap; synchroniser lag only ever over-estimates the level.
  assign w_rbin  = gray2bin(r_rptr_sync);
  assign w_level = waddr - w_rbin;

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      r_s1          <= '0;
      r_rptr_sync   <= '0;
      r_wr_level    <= '0;
      r_almost_full <= 1'b0;
    end else begin
      r_s1          <= rptr_gray;
      r_rptr_sync   <= r_s1;
      r_wr_level    <= w_level;
      r_almost_full <= (w_level >= AFULL);
    end
  end

  assign rptr_sync   = r_rptr_sync;
  assign wr_level    = r_wr_level;
  assign almost_full = r_almost_full;

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Bench for wr_ingress_ctrl: directed scenarios plus random traffic, checked against a
// queue-based occupancy model and a delay-line model of the pointer path.
module tb_wr_ingress_ctrl;

  localparam int PW = 3;
  localparam int DW = 8;
  localparam int AF = 6;

  logic          wclk = 1'b0;
  logic          w_rst_n, in_valid, full, in_ready, w_en, almost_full;
  logic [DW-1:0] in_data, wdata;
  logic [PW:0]   waddr, rptr_gray, rptr_sync, wr_level;

  int n_checks = 0;
  int n_errs   = 0;

  logic [DW-1:0] q[$];
  logic [PW:0]   m_s1, m_sync, m_level;
  logic          m_af;
  bit            m_init = 1'b0;

  always #5 wclk = ~wclk;

  wr_ingress_ctrl #(.ptr_width(PW), .data_width(DW), .afull_thresh(AF)) dut (
    .wclk(wclk), .w_rst_n(w_rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .full(full), .waddr(waddr), .rptr_gray(rptr_gray),
    .w_en(w_en), .wdata(wdata), .rptr_sync(rptr_sync), .wr_level(wr_level),
    .almost_full(almost_full)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [PW:0] g2b(input logic [PW:0] g);
    logic [PW:0] b = g;
    for (int k = 1; k <= PW; k++) b = b ^ (g >> k);
    return b;
  endfunction

  // Apply inputs for the coming cycle, then compare every output against the model.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f,
                       input logic [PW:0] wa, input logic [PW:0] g, input logic rn);
    in_valid = v; in_data = d; full = f; waddr = wa; rptr_gray = g; w_rst_n = rn;
    #1;
    if (m_init) begin
      chk("w_en", w_en, (q.size() > 0) && !f && rn);
      chk("in_ready", in_ready, (q.size() < 2) && rn);
      if (q.size() > 0) chk("wdata", wdata, q[0]);
      chk("rptr_sync", rptr_sync, m_sync);
      chk("wr_level", wr_level, m_level);
      chk("almost_full", almost_full, m_af);
    end
  endtask

  task automatic tick();
    bit acc, drn;
    logic [PW:0] lvl;
    acc = in_valid && (q.size() < 2) && w_rst_n;
    drn = (q.size() > 0) && !full && w_rst_n;
    @(posedge wclk);
    if (!w_rst_n) begin
      q.delete();
      m_s1 = '0; m_sync = '0; m_level = '0; m_af = 1'b0;
    end else begin
      lvl     = waddr - g2b(m_sync);
      m_level = lvl;
      m_af    = (int'(lvl) >= AF);
      m_sync  = m_s1;
      m_s1    = rptr_gray;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    m_init = 1'b1;
    #1;
  endtask

  initial begin
    // Reset held two cycles with traffic present
    drive(1, 8'h11, 0, 0, 4'd5, 0); tick();
    drive(1, 8'h11, 0, 0, 4'd5, 0);
    chk("rst_w_en", w_en, 0); chk("rst_in_ready", in_ready, 0);
    tick();
    drive(0, 8'h00, 0, 0, 4'd5, 1);
    chk("rst_rptr_sync", rptr_sync, 0); chk("rst_wr_level", wr_level, 0);
    chk("rst_afull", almost_full, 0); chk("rst_wdata", wdata, 0);
    chk("rel_in_ready", in_ready, 1);
    tick();
    repeat (3) begin drive(0, 8'h00, 0, 0, 0, 1); tick(); end

    // Single word
    drive(1, 8'hA5, 0, 0, 0, 1); tick();
    drive(0, 8'h00, 0, 0, 0, 1);
    chk("single_w_en", w_en, 1); chk("single_wdata", wdata, 8'hA5);
    tick();
    drive(0, 8'h00, 0, 0, 0, 1); chk("single_idle", w_en, 0); tick();

    // Backpressure
    drive(1, 8'h01, 1, 0, 0, 1); tick();
    drive(1, 8'h02, 1, 0, 0, 1); tick();
    drive(1, 8'h03, 1, 0, 0, 1);
    chk("bp_in_ready", in_ready, 0); chk("bp_wdata_held", wdata, 8'h01); chk("bp_w_en", w_en, 0);
    tick();
    drive(1, 8'h03, 0, 0, 0, 1); chk("bp_drain1", wdata, 8'h01); chk("bp_we1", w_en, 1); tick();
    drive(1, 8'h03, 0, 0, 0, 1); chk("bp_drain2", wdata, 8'h02); chk("bp_we2", w_en, 1); tick();
    drive(0, 8'h00, 0, 0, 0, 1); chk("bp_drain3", wdata, 8'h03); chk("bp_we3", w_en, 1); tick();
    drive(0, 8'h00, 0, 0, 0, 1); chk("bp_done", w_en, 0); tick();

    // Synchroniser latency
    repeat (3) begin drive(0, 0, 0, 4'd5, 4'd0, 1); tick(); end
    drive(0, 0, 0, 4'd5, 4'd1, 1); tick();
    drive(0, 0, 0, 4'd5, 4'd1, 1); chk("sync_n", rptr_sync, 0); tick();
    drive(0, 0, 0, 4'd5, 4'd1, 1); chk("sync_n1", rptr_sync, 1); tick();
    drive(0, 0, 0, 4'd5, 4'd1, 1); chk("sync_level", wr_level, 4); tick();

    // Wrap and almost-full
    repeat (3) begin drive(0, 0, 0, 4'd1, 4'b1001, 1); tick(); end
    drive(0, 0, 0, 4'd1, 4'b1001, 1);
    chk("wrap_level", wr_level, 3); chk("wrap_afull", almost_full, 0);
    tick();
    repeat (3) begin drive(0, 0, 0, 4'd6, 4'd0, 1); tick(); end
    drive(0, 0, 0, 4'd6, 4'd0, 1);
    chk("af_level", wr_level, 6); chk("af_flag", almost_full, 1);
    tick();

    // Reset mid-operation with both entries occupied
    drive(1, 8'h31, 1, 0, 0, 1); tick();
    drive(1, 8'h32, 1, 0, 0, 1); tick();
    drive(1, 8'h33, 1, 0, 0, 1); chk("mid_full_ready", in_ready, 0); tick();
    drive(1, 8'h33, 0, 0, 0, 0); chk("mid_rst_w_en", w_en, 0); tick();
    drive(1, 8'h7E, 0, 0, 0, 1);
    chk("mid_rel_ready", in_ready, 1); chk("mid_no_stale", w_en, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0, 1); chk("mid_first_w_en", w_en, 1); chk("mid_first_wdata", wdata, 8'h7E); tick();
    drive(0, 8'h00, 0, 0, 0, 1); chk("mid_after", w_en, 0); tick();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) == 0,
            (PW+1)'($urandom), (PW+1)'($urandom), $urandom_range(0, 49) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
